// File: rtl/score4_pkg.sv
// Shared types and constants for the Score 4 game core: board geometry,
// cell codes, board storage type and the turn sequencer state encoding.
package score4_pkg;

  localparam int COLS = 7;
  localparam int ROWS = 6;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [COLS-1:0] PLAY_RESET = 7'b0001000;

  // panel[col][row]; row 0 is the top of the board
  typedef logic [COLS-1:0][ROWS-1:0][1:0] panel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DROP,
    ST_COMMIT,
    ST_EVAL,
    ST_OVER
  } turn_state_t;

  function automatic logic [2:0] col_index(input logic [COLS-1:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int c = 0; c < COLS; c++) begin
      if (onehot[c]) idx = 3'(c);
    end
    return idx;
  endfunction

  function automatic logic [1:0] player_code(input logic turn);
    return turn ? P2 : P1;
  endfunction

endpackage

// File: rtl/score4_turn_ctrl_free_row.sv
// Landing-row finder: lowest empty cell (largest row index) of the column
// selected by the one-hot cursor; valid drops low when the column is full.
module free_row
  import score4_pkg::*;
(
  input  panel_t            panel,
  input  logic [COLS-1:0]   play,
  output logic [2:0]        free,
  output logic              valid
);

  logic [ROWS-1:0][1:0] col_cells;

  always_comb begin
    col_cells = '0;
    // one-hot select done as an OR-mux
    for (int c = 0; c < COLS; c++) begin
      if (play[c]) col_cells = col_cells | panel[c];
    end
  end

  always_comb begin
    free  = 3'd0;
    valid = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (col_cells[r] == EMPTY) begin
        free  = 3'(r);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score4_turn_ctrl.sv
// Turn sequencer: owns the board, cursor and turn; animates each drop,
// commits the disc and samples the external win checker to end the game.
//
// state  | meaning
// IDLE   | waiting for cursor moves or a put
// CHECK  | latch landing row from free_row, reject full columns
// DROP   | falling-disc animation, DROP_TICKS cycles per row
// COMMIT | write the disc into the board, count the move
// EVAL   | sample win, detect a full board, hand over the turn
// OVER   | game finished, only new_game is honoured
module score4_turn_ctrl
  import score4_pkg::*;
#(
  parameter int DROP_TICKS = 4,
  parameter int MAX_MOVES  = 42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              left,
  input  logic              right,
  input  logic              put,
  input  logic              new_game,
  input  logic              win,
  output panel_t            panel,
  output logic [COLS-1:0]   play,
  output logic              turn,
  output logic              dropping,
  output logic [2:0]        anim_row,
  output logic              invalid,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic              draw
);

  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DROP_TICKS - 1);
  localparam logic [5:0]    MOVES_FULL = 6'(MAX_MOVES);

  turn_state_t       state_q, state_d;
  panel_t            panel_q, panel_d;
  logic [COLS-1:0]   play_q, play_d;
  logic              turn_q, turn_d;
  logic [5:0]        moves_q, moves_d;
  logic [2:0]        anim_row_q, anim_row_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        tgt_row_q, tgt_row_d;
  logic              tgt_ok_q, tgt_ok_d;
  logic              invalid_q, invalid_d;
  logic [1:0]        winner_q, winner_d;
  logic              draw_q, draw_d;

  logic [2:0]        fr_free;
  logic              fr_valid;
  logic [2:0]        col_idx;

  free_row u_free_row (
    .panel (panel_q),
    .play  (play_q),
    .free  (fr_free),
    .valid (fr_valid)
  );

  // play_q only changes in IDLE, so it still names the target column later
  assign col_idx = col_index(play_q);

  always_comb begin
    state_d    = state_q;
    panel_d    = panel_q;
    play_d     = play_q;
    turn_d     = turn_q;
    moves_d    = moves_q;
    anim_row_d = anim_row_q;
    tick_d     = tick_q;
    tgt_row_d  = tgt_row_q;
    tgt_ok_d   = tgt_ok_q;
    invalid_d  = 1'b0;
    winner_d   = winner_q;
    draw_d     = draw_q;

    if (new_game) begin
      state_d    = ST_IDLE;
      panel_d    = '0;
      play_d     = PLAY_RESET;
      turn_d     = 1'b0;
      moves_d    = 6'd0;
      anim_row_d = 3'd0;
      tick_d     = '0;
      tgt_row_d  = 3'd0;
      tgt_ok_d   = 1'b0;
      winner_d   = EMPTY;
      draw_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (put) begin
            state_d = ST_CHECK;
          end else if (left && !right) begin
            play_d = {play_q[0], play_q[COLS-1:1]};
          end else if (right && !left) begin
            play_d = {play_q[COLS-2:0], play_q[COLS-1]};
          end
        end

        ST_CHECK: begin
          tgt_row_d = fr_free;
          tgt_ok_d  = fr_valid;
          if (!fr_valid) begin
            invalid_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            anim_row_d = 3'd0;
            tick_d     = '0;
            state_d    = ST_DROP;
          end
        end

        ST_DROP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (anim_row_q == tgt_row_q) state_d = ST_COMMIT;
            else anim_row_d = anim_row_q + 3'd1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_COMMIT: begin
          panel_d[col_idx][tgt_row_q] = player_code(turn_q);
          moves_d = moves_q + 6'd1;
          state_d = ST_EVAL;
        end

        ST_EVAL: begin
          if (win) begin
            winner_d = player_code(turn_q);
            state_d  = ST_OVER;
          end else if (moves_q == MOVES_FULL) begin
            draw_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_IDLE;
          end
        end

        ST_OVER: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      panel_q    <= '0;
      play_q     <= PLAY_RESET;
      turn_q     <= 1'b0;
      moves_q    <= 6'd0;
      anim_row_q <= 3'd0;
      tick_q     <= '0;
      tgt_row_q  <= 3'd0;
      tgt_ok_q   <= 1'b0;
      invalid_q  <= 1'b0;
      winner_q   <= EMPTY;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      panel_q    <= panel_d;
      play_q     <= play_d;
      turn_q     <= turn_d;
      moves_q    <= moves_d;
      anim_row_q <= anim_row_d;
      tick_q     <= tick_d;
      tgt_row_q  <= tgt_row_d;
      tgt_ok_q   <= tgt_ok_d;
      invalid_q  <= invalid_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
    end
  end

  assign panel     = panel_q;
  assign play      = play_q;
  assign turn      = turn_q;
  assign dropping  = (state_q == ST_DROP);
  assign anim_row  = anim_row_q;
  assign invalid   = invalid_q;
  assign game_over = (state_q == ST_OVER);
  assign winner    = winner_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_score4_turn_ctrl.sv
// Bench for score4_turn_ctrl: stimulus tasks queue time-stamped expectations,
// a negedge monitor compares each one in the cycle it falls due.
module tb_score4_turn_ctrl;
  import score4_pkg::*;

  localparam int DT  = 2;
  localparam int MAX = 42;

  localparam int K_PLAY  = 0;
  localparam int K_TURN  = 1;
  localparam int K_DROP  = 2;
  localparam int K_ANIM  = 3;
  localparam int K_INV   = 4;
  localparam int K_OVER  = 5;
  localparam int K_WIN   = 6;
  localparam int K_DRAW  = 7;
  localparam int K_CELL  = 8;
  localparam int K_BLANK = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left = 1'b0, right = 1'b0, put = 1'b0, new_game = 1'b0, win = 1'b0;
  panel_t      panel;
  logic [6:0]  play;
  logic        turn, dropping, invalid, game_over, draw;
  logic [2:0]  anim_row;
  logic [1:0]  winner;

  score4_turn_ctrl #(.DROP_TICKS(DT), .MAX_MOVES(MAX)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .new_game(new_game), .win(win), .panel(panel), .play(play),
    .turn(turn), .dropping(dropping), .anim_row(anim_row),
    .invalid(invalid), .game_over(game_over), .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int q_due[$], q_kind[$], q_col[$], q_row[$], q_val[$];
  string q_name[$];

  // bench model
  int m_h[7];
  int m_turn, m_moves;

  function automatic int actual_of(input int k, input int c, input int r);
    case (k)
      K_PLAY:  return int'(play);
      K_TURN:  return int'(turn);
      K_DROP:  return int'(dropping);
      K_ANIM:  return int'(anim_row);
      K_INV:   return int'(invalid);
      K_OVER:  return int'(game_over);
      K_WIN:   return int'(winner);
      K_DRAW:  return int'(draw);
      K_CELL:  return int'(panel[c][r]);
      K_BLANK: return (panel == '0) ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic expect_at(input int due, input int k, input int c, input int r,
                           input int v, input string nm);
    q_due.push_back(due); q_kind.push_back(k); q_col.push_back(c);
    q_row.push_back(r); q_val.push_back(v); q_name.push_back(nm);
  endtask

  always @(negedge clk) begin
    for (int i = q_due.size() - 1; i >= 0; i--) begin
      if (q_due[i] == cyc) begin
        int a;
        a = actual_of(q_kind[i], q_col[i], q_row[i]);
        checks++;
        if (a != q_val[i]) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", q_name[i], cyc, a, q_val[i]);
        end
        q_due.delete(i); q_kind.delete(i); q_col.delete(i);
        q_row.delete(i); q_val.delete(i); q_name.delete(i);
      end
    end
  end

  task automatic model_reset();
    for (int c = 0; c < 7; c++) m_h[c] = 0;
    m_turn = 0;
    m_moves = 0;
  endtask

  task automatic expect_clean(input int due, input string nm);
    expect_at(due, K_BLANK, 0, 0, 1, {nm, "_blank"});
    expect_at(due, K_PLAY, 0, 0, 7'b0001000, {nm, "_play"});
    expect_at(due, K_TURN, 0, 0, 0, {nm, "_turn"});
    expect_at(due, K_DROP, 0, 0, 0, {nm, "_dropping"});
    expect_at(due, K_ANIM, 0, 0, 0, {nm, "_anim"});
    expect_at(due, K_INV, 0, 0, 0, {nm, "_invalid"});
    expect_at(due, K_OVER, 0, 0, 0, {nm, "_over"});
    expect_at(due, K_WIN, 0, 0, 0, {nm, "_winner"});
    expect_at(due, K_DRAW, 0, 0, 0, {nm, "_draw"});
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_lr(input logic l, input logic r, input int exp_play);
    @(negedge clk);
    left = l; right = r;
    expect_at(cyc + 1, K_PLAY, 0, 0, exp_play, "cursor");
    @(negedge clk);
    left = 0; right = 0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1;
    expect_clean(cyc + 1, "new_game");
    @(negedge clk);
    new_game = 0;
    model_reset();
  endtask

  task automatic do_put_valid(input int col, input bit w, input bit full_anim,
                              input bit with_left);
    int t, r, code, span, done;
    @(negedge clk);
    put = 1; win = w; left = with_left;
    t = cyc;
    r = 5 - m_h[col];
    code = (m_turn != 0) ? 2 : 1;
    span = (r + 1) * DT;
    done = t + 4 + span;
    expect_at(t + 1, K_DROP, 0, 0, 0, "check_not_dropping");
    expect_at(t + 1, K_PLAY, 0, 0, 1 << col, "cursor_frozen");
    expect_at(t + 2, K_DROP, 0, 0, 1, "drop_start");
    expect_at(t + 2, K_ANIM, 0, 0, 0, "anim_first_row");
    expect_at(t + 2, K_INV, 0, 0, 0, "no_invalid");
    if (full_anim) begin
      for (int i = 1; i < span; i++)
        expect_at(t + 2 + i, K_ANIM, 0, 0, i / DT, "anim_row_seq");
    end
    expect_at(t + 1 + span, K_ANIM, 0, 0, r, "anim_last_row");
    expect_at(t + 1 + span, K_DROP, 0, 0, 1, "drop_last");
    expect_at(t + 2 + span, K_DROP, 0, 0, 0, "commit_not_dropping");
    expect_at(t + 2 + span, K_CELL, col, r, 0, "cell_before_commit");
    expect_at(t + 3 + span, K_CELL, col, r, code, "cell_after_commit");
    expect_at(t + 3 + span, K_TURN, 0, 0, m_turn, "turn_in_eval");
    m_h[col]++;
    m_moves++;
    if (w) begin
      expect_at(done, K_OVER, 0, 0, 1, "win_over");
      expect_at(done, K_WIN, 0, 0, code, "winner_code");
      expect_at(done, K_DRAW, 0, 0, 0, "win_not_draw");
    end else if (m_moves == MAX) begin
      expect_at(done, K_OVER, 0, 0, 1, "draw_over");
      expect_at(done, K_DRAW, 0, 0, 1, "draw_flag");
      expect_at(done, K_WIN, 0, 0, 0, "draw_winner");
    end else begin
      m_turn ^= 1;
      expect_at(done, K_OVER, 0, 0, 0, "not_over");
      expect_at(done, K_DRAW, 0, 0, 0, "not_draw");
    end
    expect_at(done, K_TURN, 0, 0, m_turn, "turn_after_move");
    @(negedge clk);
    put = 0; left = 0;
    wait_until(done);
    win = 0;
  endtask

  task automatic do_put_invalid(input int col);
    int t;
    @(negedge clk);
    put = 1;
    t = cyc;
    expect_at(t + 1, K_INV, 0, 0, 0, "invalid_early");
    expect_at(t + 2, K_INV, 0, 0, 1, "invalid_pulse");
    expect_at(t + 2, K_DROP, 0, 0, 0, "invalid_no_drop");
    expect_at(t + 3, K_INV, 0, 0, 0, "invalid_single");
    expect_at(t + 3, K_DROP, 0, 0, 0, "invalid_idle");
    expect_at(t + 3, K_TURN, 0, 0, m_turn, "invalid_turn");
    expect_at(t + 3, K_CELL, col, 0, (m_turn != 0) ? 1 : 2, "invalid_top_cell");
    expect_at(t + 3, K_CELL, col + 1, 5, 0, "invalid_neighbour");
    @(negedge clk);
    put = 0;
    wait_until(t + 4);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    expect_clean(cyc + 1, "reset");

    // cursor: wrap both ways, simultaneous left/right ignored
    pulse_lr(0, 1, 7'b0010000);
    pulse_lr(0, 1, 7'b0100000);
    pulse_lr(0, 1, 7'b1000000);
    pulse_lr(0, 1, 7'b0000001);
    pulse_lr(1, 0, 7'b1000000);
    pulse_lr(1, 1, 7'b1000000);
    pulse_lr(1, 0, 7'b0100000);
    pulse_lr(1, 0, 7'b0010000);
    pulse_lr(1, 0, 7'b0001000);

    // full animation drop into an empty column, left ignored alongside put
    do_put_valid(3, 0, 1, 1);

    // abort mid-drop on row 5
    pulse_new_game();
    begin
      int t;
      @(negedge clk);
      put = 1;
      t = cyc;
      expect_at(t + 12, K_ANIM, 0, 0, 5, "abort_anim_row5");
      expect_at(t + 12, K_DROP, 0, 0, 1, "abort_dropping");
      @(negedge clk);
      put = 0;
      wait_until(t + 12);
      new_game = 1;
      expect_clean(t + 13, "abort");
      expect_at(t + 16, K_BLANK, 0, 0, 1, "abort_no_late_write");
      expect_at(t + 16, K_DROP, 0, 0, 0, "abort_stays_idle");
      @(negedge clk);
      new_game = 0;
      model_reset();
      wait_until(t + 17);
    end

    // player 2 wins, then OVER ignores put/left
    do_put_valid(3, 0, 0, 0);
    do_put_valid(3, 1, 0, 0);
    begin
      int t;
      @(negedge clk);
      put = 1; left = 1;
      t = cyc;
      expect_at(t + 1, K_PLAY, 0, 0, 7'b0001000, "over_cursor");
      expect_at(t + 2, K_DROP, 0, 0, 0, "over_no_drop");
      expect_at(t + 16, K_CELL, 3, 3, 0, "over_panel_frozen");
      expect_at(t + 16, K_OVER, 0, 0, 1, "over_holds");
      expect_at(t + 16, K_WIN, 0, 0, 2, "over_winner_holds");
      @(negedge clk);
      put = 0; left = 0;
      wait_until(t + 17);
    end

    // fill the board with no win; a rejected put in the middle must not count
    pulse_new_game();
    pulse_lr(1, 0, 7'b0000100);
    pulse_lr(1, 0, 7'b0000010);
    pulse_lr(1, 0, 7'b0000001);
    for (int k = 0; k < 6; k++) do_put_valid(0, 0, 0, 0);
    do_put_invalid(0);
    for (int c = 1; c < 7; c++) begin
      pulse_lr(0, 1, 1 << c);
      for (int k = 0; k < 6; k++) do_put_valid(c, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    if (q_due.size() != 0) begin
      failures += q_due.size();
      $display("FAIL pending_expectations count=%0d required=0", q_due.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
